// File: rtl/lspc_timer_irq.sv
// Raster-locked pixel timer with level interrupts (timer, vblank, reset) for the LSPC block.
// Optional build macro TIMER_PAL_STOP_EN: freeze counting on early PAL lines when MODE bit7 is set.
module lspc_timer_irq (
    input  logic        CLK_24MB,
    input  logic        RESETP,
    input  logic        PIXEL_EN,
    input  logic        VBLANK,
    input  logic [8:0]  RASTERC,
    input  logic        VMODE,
    input  logic        REG_WR,
    input  logic [1:0]  REG_ADDR,
    input  logic [15:0] REG_DATA,
    output logic [31:0] TIMER_CNT,
    output logic [3:0]  MODE,
    output logic        IRQ_TIMER,
    output logic        IRQ_VBL,
    output logic        IRQ_RESET
);

    logic [31:0] cnt_q, cnt_d;
    logic [15:0] rel_hi_q, rel_hi_d;
    logic [15:0] rel_lo_q, rel_lo_d;
    logic [3:0]  mode_q, mode_d;
    logic        irq_tmr_q, irq_tmr_d;
    logic        irq_vbl_q, irq_vbl_d;
    logic        irq_rst_q, irq_rst_d;
    logic        vbl_low_q, vbl_low_d;

    logic        pal_hold_s;
    logic        count_en_s;
    logic        vbl_rise_s;
    logic        tc_s;
    logic        wr_hi_s, wr_lo_s, wr_mode_s, wr_ack_s;

`ifdef TIMER_PAL_STOP_EN
    assign pal_hold_s = VMODE & mode_q[3] & (RASTERC < 9'h010);
`else
    logic unused_pal_s;
    assign unused_pal_s = ^{VMODE, RASTERC};
    assign pal_hold_s   = 1'b0;
`endif

    // vbl_low_q remembers VBLANK was low last cycle, so a level held high out of reset is not an edge
    assign vbl_rise_s = VBLANK & vbl_low_q;
    assign count_en_s = PIXEL_EN & ~pal_hold_s;
    assign tc_s       = count_en_s & (cnt_q == 32'h0000_0000);

    // Register-write decode
    always_comb begin
        wr_hi_s   = 1'b0;
        wr_lo_s   = 1'b0;
        wr_mode_s = 1'b0;
        wr_ack_s  = 1'b0;
        if (REG_WR) begin
            case (REG_ADDR)
                2'd0:    wr_hi_s   = 1'b1;
                2'd1:    wr_lo_s   = 1'b1;
                2'd2:    wr_mode_s = 1'b1;
                2'd3:    wr_ack_s  = 1'b1;
                default: wr_ack_s  = 1'b0;
            endcase
        end else begin
            wr_ack_s = 1'b0;
        end
    end

    // Next-state logic for registers, counter and interrupt flags
    always_comb begin
        rel_hi_d  = wr_hi_s   ? REG_DATA      : rel_hi_q;
        rel_lo_d  = wr_lo_s   ? REG_DATA      : rel_lo_q;
        mode_d    = wr_mode_s ? REG_DATA[7:4] : mode_q;
        vbl_low_d = ~VBLANK;

        if (wr_lo_s && mode_q[1]) begin
            cnt_d = {rel_hi_q, REG_DATA};
        end else if (vbl_rise_s && mode_q[2]) begin
            cnt_d = {rel_hi_q, rel_lo_q};
        end else if (tc_s && mode_q[3]) begin
            cnt_d = {rel_hi_q, rel_lo_q};
        end else if (count_en_s) begin
            cnt_d = cnt_q - 32'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // A new cause in the same cycle as its ack keeps the flag set
        irq_tmr_d = (tc_s & mode_q[0]) | (irq_tmr_q & ~(wr_ack_s & REG_DATA[1]));
        irq_vbl_d = vbl_rise_s         | (irq_vbl_q & ~(wr_ack_s & REG_DATA[2]));
        irq_rst_d = irq_rst_q & ~(wr_ack_s & REG_DATA[0]);
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK_24MB) begin
        if (RESETP) begin
            cnt_q     <= 32'h0000_0000;
            rel_hi_q  <= 16'h0000;
            rel_lo_q  <= 16'h0000;
            mode_q    <= 4'h0;
            irq_tmr_q <= 1'b0;
            irq_vbl_q <= 1'b0;
            irq_rst_q <= 1'b1;
            vbl_low_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rel_hi_q  <= rel_hi_d;
            rel_lo_q  <= rel_lo_d;
            mode_q    <= mode_d;
            irq_tmr_q <= irq_tmr_d;
            irq_vbl_q <= irq_vbl_d;
            irq_rst_q <= irq_rst_d;
            vbl_low_q <= vbl_low_d;
        end
    end

    assign TIMER_CNT = cnt_q;
    assign MODE      = mode_q;
    assign IRQ_TIMER = irq_tmr_q;
    assign IRQ_VBL   = irq_vbl_q;
    assign IRQ_RESET = irq_rst_q;

endmodule

// File: doc/lspc_timer_irq.md
# lspc_timer_irq

Raster-locked programmable timer and interrupt controller for the LSPC video block. Counts pixel-clock strobes derived from the pixel counter, reloads from CPU-written registers on CPU write, vblank start or terminal count, and raises the three level interrupts (timer, vblank, reset) that the CPU acknowledges by register write. It sits beside the video sync generator: it consumes its pixel strobe, raster count and blanking, and feeds the 68k interrupt encoder.

## Interface
- CLK_24MB  in  1  master clock; all state updates on rising edge
- RESETP  in  1  reset, synchronous, active-high
- PIXEL_EN  in  1  one-cycle strobe per pixel (6 MHz rate); gates counting
- VBLANK  in  1  active-high vertical blank level from video sync
- RASTERC  in  9  current raster line
- VMODE  in  1  1 = PAL, 0 = NTSC (used only under TIMER_PAL_STOP_EN)
- REG_WR  in  1  one-cycle CPU register write strobe
- REG_ADDR  in  2  0 = reload high, 1 = reload low, 2 = mode, 3 = IRQ ack
- REG_DATA  in  16  write data
- TIMER_CNT  out  32  live counter value
- MODE  out  4  mode register bits [7:4] readback
- IRQ_TIMER  out  1  timer interrupt pending
- IRQ_VBL  out  1  vblank interrupt pending
- IRQ_RESET  out  1  reset interrupt pending

## Operation
- Registers: RELOAD[31:16] (addr 0), RELOAD[15:0] (addr 1), MODE = REG_DATA[7:4] (addr 2): bit4 IRQ enable, bit5 load-on-low-write, bit6 load-at-vblank, bit7 load-at-zero (and PAL stop, see Configuration).
- Counter load priority per cycle: reset > load-on-write > vblank load > zero load > decrement.
- Load-on-write: write to addr 1 with MODE bit5 = 1 loads counter with {RELOAD[31:16], REG_DATA}.
- Vblank load: on VBLANK rising edge (registered edge detect) with bit6 = 1, counter <= RELOAD.
- Decrement: on PIXEL_EN, counter - 1, mod 2^32.
- Terminal count: on PIXEL_EN with counter == 0: if bit4, IRQ_TIMER <= 1; if bit7, counter <= RELOAD, else wraps to 0xFFFFFFFF.
- IRQ_VBL <= 1 on every VBLANK rising edge regardless of MODE.
- Ack (addr 3): REG_DATA bit0 clears IRQ_RESET, bit1 clears IRQ_TIMER, bit2 clears IRQ_VBL; multiple bits allowed. Set and ack of same flag in same cycle: set wins.
- Writes to addrs 0 and 2 never change the counter.

## Timing
- Reset values: TIMER_CNT 0, RELOAD 0, MODE 0, IRQ_TIMER 0, IRQ_VBL 0, IRQ_RESET 1, edge-detect register 0.
- Register writes visible on outputs the cycle after REG_WR.
- Counter loads/decrements visible one cycle after the qualifying strobe or edge.
- IRQ flags assert one cycle after the cause; deassert one cycle after ack.
- VBLANK edge counted once: a VBLANK already high out of reset produces no edge until it falls and rises again.
- Reset mid-count: all state returns to reset values the next cycle; pending flags lost except IRQ_RESET set.

## Configuration
- TIMER_PAL_STOP_EN defined: when VMODE = 1 and MODE bit7 = 1, PIXEL_EN is ignored (no decrement, no terminal-count event) while RASTERC < 9'h010; loads still occur.
- Undefined: VMODE ignored; counting depends only on PIXEL_EN.

## Test plan
- Reset, then write ack 0x0001 -> IRQ_RESET 1 after reset, 0 one cycle after write; other outputs 0 throughout.
- MODE = 0x0030, write high 0x0000, low 0x0003, 4 PIXEL_EN strobes -> TIMER_CNT 3,2,1,0, then IRQ_TIMER 1 and TIMER_CNT 0xFFFFFFFF.
- MODE = 0x00D0, RELOAD 0x00000002, count to zero -> reloads 2, IRQ_TIMER 1; ack 0x0002 in same cycle as next terminal count -> IRQ_TIMER stays 1.
- MODE = 0x0040, RELOAD 0x12345678, VBLANK 0->1 -> TIMER_CNT 0x12345678 and IRQ_VBL 1 next cycle; VBLANK held high 100 cycles -> no further load.
- Write low with MODE bit5 and vblank edge same cycle -> counter = {RELOAD_hi, REG_DATA}, IRQ_VBL still set.
- With TIMER_PAL_STOP_EN, VMODE = 1, MODE = 0x0080, RASTERC 0x00F and 10 strobes -> counter unchanged; RASTERC 0x010 -> decrements resume.
